flash_spi_arbiter: RTL
======================

Name: flash_spi_arbiter

Overview:
- Shares the single external SPI flash bus between two masters:
  - the management SoC flash controller (default owner);
  - the housekeeping SPI pass-thru path, entered after command 0xC4.
- Sequences ownership hand-over:
  - holds the CPU in reset while pass-thru owns the flash;
  - drives guard intervals with the flash deselected;
  - releases the CPU so it re-boots from flash once pass-thru ends.
- Sits between housekeeping, the mgmt core and the flash pads.

Parameters:
- SYNC_STAGES, 2: flops in the pt_req_i synchronizer (≥2).
- GUARD_CYCLES, 8: idle cycles with flash_csb_o=1 before and after pass-thru ownership (≥1).
- CNT_W, 8: guard counter width; GUARD_CYCLES < 2**CNT_W.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- mgmt_csb_i  in  1  mgmt flash chip select (wb_clk_i domain).
- mgmt_sck_i  in  1  mgmt flash clock.
- mgmt_io_do_i  in  2  mgmt flash io[1:0] output data.
- mgmt_io_oeb_i  in  2  mgmt flash io[1:0] output enable, active low.
- mgmt_io_di_o  out  2  flash io[1:0] input data returned to mgmt.
- pt_req_i  in  1  pass-thru request from housekeeping; asynchronous; high from 0xC4 decode until hk CSB rises.
- pt_csb_i  in  1  housekeeping SPI CSB, passed through.
- pt_sck_i  in  1  housekeeping SPI SCK, passed through.
- pt_sdi_i  in  1  housekeeping SPI SDI, routed to flash io0.
- pt_sdo_o  out  1  flash io1 returned to housekeeping SDO.
- pt_grant_o  out  1  pass-thru owns the flash bus.
- flash_csb_o  out  1  flash pad chip select.
- flash_clk_o  out  1  flash pad clock.
- flash_io_do_o  out  2  flash pad io[1:0] output data.
- flash_io_oeb_o  out  2  flash pad io[1:0] output enable, active low.
- flash_io_di_i  in  2  flash pad io[1:0] input data.
- cpu_hold_o  out  1  holds the mgmt CPU in reset.
- busy_o  out  1  state is not MGMT.

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is asynchronous, active-high.
- Reset values: state=MGMT, counter=0, sync chain=0, cpu_hold_o=0, pt_grant_o=0, busy_o=0.
- Outputs while wb_rst_i=1 are forced idle: flash_csb_o=1, flash_clk_o=0, flash_io_do_o=00, flash_io_oeb_o=11, mgmt_io_di_o=00, pt_sdo_o=0.
- Pad mux:
  - combinational, selected only by the registered state, so no glitch is caused by the select;
  - SPI data and clock pass combinationally so external SCK timing is preserved.
- pt_req_s is pt_req_i after SYNC_STAGES flops.
- MGMT:
  - all flash_* outputs follow mgmt_*; mgmt_io_di_o=flash_io_di_i; pt_sdo_o=0.
  - pt_req_s=1 → DRAIN; counter cleared; cpu_hold_o=1 from the next edge.
- DRAIN:
  - pads idle (csb=1, clk=0, do=00, oeb=11); mgmt_io_di_o=00.
  - Counter increments each cycle; at GUARD_CYCLES-1 → PASS.
  - If pt_req_s drops during DRAIN, still complete to PASS then exit. The sequence is never abandoned mid-way.
- PASS:
  - pt_grant_o=1.
  - Pad drive: flash_csb_o=pt_csb_i, flash_clk_o=pt_sck_i, flash_io_do_o={0,pt_sdi_i}, flash_io_oeb_o=10.
  - pt_sdo_o=flash_io_di_i[1]; mgmt_io_di_o=00.
  - pt_req_s=0 → RELEASE; counter cleared.
- RELEASE:
  - pads idle; cpu_hold_o stays 1.
  - At GUARD_CYCLES-1 → MGMT; cpu_hold_o=0 on that same edge.
  - pt_req_s rising during RELEASE is ignored. At least one cycle is spent in MGMT, then DRAIN re-enters if the request is still high.
- Latency (request asserted at pad to pt_grant_o=1): SYNC_STAGES + 1 + GUARD_CYCLES cycles.
- Latency (request dropped to cpu_hold_o=0): SYNC_STAGES + 1 + GUARD_CYCLES cycles.
- Reset mid-operation: immediate return to MGMT with cpu_hold_o=0; pads idle until reset deasserts.
- busy_o=1 in DRAIN, PASS and RELEASE.

Decomposition:
- Package flash_arb_pkg holds:
  - state encoding localparams: MGMT=2'd0, DRAIN=2'd1, PASS=2'd2, RELEASE=2'd3;
  - OEB_IDLE=2'b11 and OEB_PT=2'b10.
- One sub-module, flash_arb_sync: a parameterised SYNC_STAGES flop synchronizer with async active-high reset, used for pt_req_i.

Test Plan:
- Reset idle: assert wb_rst_i with mgmt_csb_i=0 and mgmt_sck_i toggling → flash_csb_o=1, flash_io_oeb_o=11, cpu_hold_o=0.
- Release into MGMT: deassert reset → outputs follow mgmt_* within 0 cycles and busy_o=0.
- Entry timing (defaults): pt_req_i 0→1 at cycle 0:
  - cpu_hold_o=1 at cycle 3;
  - pt_grant_o=1 at cycle 11;
  - flash_csb_o=1 throughout cycles 3–10.
- Pass-thru read: in PASS, drive 0x03 00 00 00 on pt_sdi_i with the flash model loaded with 6F 00 00 0B → pt_sdo_o shifts back 0x6F, 0x00, 0x00, 0x0B and flash_io_oeb_o=10.
- Exit timing: pt_req_i 1→0 → pads idle for 8 cycles; then cpu_hold_o=0 and MGMT resumes. A subsequent mgmt read of address 0 returns 0x6F.
- Corner cases:
  - pulse pt_req_i for 1 cycle → full DRAIN/PASS/RELEASE sequence runs, PASS lasts ≥1 cycle;
  - re-request during RELEASE → exactly one MGMT cycle, then DRAIN;
  - wb_rst_i pulse while in PASS → immediate idle pads, cpu_hold_o=0.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared encodings for the SPI flash bus arbiter: FSM states and pad
// output-enable patterns.
package flash_arb_pkg;
  typedef enum logic [1:0] {
    MGMT    = 2'd0,
    DRAIN   = 2'd1,
    PASS    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] OEB_IDLE = 2'b11;
  localparam logic [1:0] OEB_PT   = 2'b10;
endpackage

// File: rtl/flash_arb_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clock
// domain. Clears to 0 on reset.
module flash_arb_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/flash_spi_arbiter.sv
// Hands the external SPI flash between the mgmt flash controller and the
// housekeeping pass-thru path, with guard intervals and CPU hold.
module flash_spi_arbiter
  import flash_arb_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       mgmt_csb_i,
  input  logic       mgmt_sck_i,
  input  logic [1:0] mgmt_io_do_i,
  input  logic [1:0] mgmt_io_oeb_i,
  output logic [1:0] mgmt_io_di_o,
  input  logic       pt_req_i,
  input  logic       pt_csb_i,
  input  logic       pt_sck_i,
  input  logic       pt_sdi_i,
  output logic       pt_sdo_o,
  output logic       pt_grant_o,
  output logic       flash_csb_o,
  output logic       flash_clk_o,
  output logic [1:0] flash_io_do_o,
  output logic [1:0] flash_io_oeb_o,
  input  logic [1:0] flash_io_di_i,
  output logic       cpu_hold_o,
  output logic       busy_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             pt_req_s;

  flash_arb_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d_i (pt_req_i),
    .q_o (pt_req_s)
  );

  // Once DRAIN starts the whole hand-over runs to completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpu_hold_d = cpu_hold_q;
    case (state_q)
      MGMT: if (pt_req_s) begin
        state_d    = DRAIN;
        cnt_d      = '0;
        cpu_hold_d = 1'b1;
      end
      DRAIN: if (cnt_q == CNT_LAST) begin
        state_d = PASS;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      PASS: if (!pt_req_s) begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: if (cnt_q == CNT_LAST) begin
        state_d    = MGMT;
        cpu_hold_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = MGMT;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= MGMT;
      cnt_q      <= '0;
      cpu_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  // Select comes only from registered state; SPI data/clock stay combinational.
  always_comb begin
    flash_csb_o    = 1'b1;
    flash_clk_o    = 1'b0;
    flash_io_do_o  = 2'b00;
    flash_io_oeb_o = OEB_IDLE;
    mgmt_io_di_o   = 2'b00;
    pt_sdo_o       = 1'b0;
    if (!wb_rst_i) begin
      case (state_q)
        MGMT: begin
          flash_csb_o    = mgmt_csb_i;
          flash_clk_o    = mgmt_sck_i;
          flash_io_do_o  = mgmt_io_do_i;
          flash_io_oeb_o = mgmt_io_oeb_i;
          mgmt_io_di_o   = flash_io_di_i;
        end
        PASS: begin
          flash_csb_o    = pt_csb_i;
          flash_clk_o    = pt_sck_i;
          flash_io_do_o  = {1'b0, pt_sdi_i};
          flash_io_oeb_o = OEB_PT;
          pt_sdo_o       = flash_io_di_i[1];
        end
        default: ;
      endcase
    end
  end

  assign pt_grant_o = (state_q == PASS);
  assign busy_o     = (state_q != MGMT);
  assign cpu_hold_o = cpu_hold_q;
endmodule
